// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 8;

  // Requester indices
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a conflict goes
// to the requester that did not win last time.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // Select the winner from the current requests and the previous grant
  always_comb begin
    valid  = req0 | req1;
    winner = REQ_CPU;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = REQ_DBG;
    end else begin
      winner = REQ_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port 32x8 data
// memory. Each grant runs IDLE -> ACC -> DONE; the memory strobes, address
// and write data are all registered so the memory sees clean signals.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              Mem_read,
  output logic              Mem_write,
  output logic [ADDR_W-1:0] Adr,
  output logic [DATA_W-1:0] Mem_in,
  input  logic [DATA_W-1:0] Mem_out
);

  arb_state_e        state_r;
  arb_state_e        next_state_s;
  logic              grant_s;
  logic              pick_valid_s;
  logic              pick_winner_s;
  logic              last_grant_r;
  logic              cmd_sel_r;
  logic              cmd_we_r;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_adr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_r),
    .valid      (pick_valid_s),
    .winner     (pick_winner_s)
  );

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          next_state_s = ACC;
          grant_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACC:     next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Route the winning requester's command fields
  always_comb begin
    if (pick_winner_s == REQ_DBG) begin
      sel_we_s    = we1;
      sel_adr_s   = adr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_adr_s   = adr0;
      sel_wdata_s = wdata0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Command register; Adr and Mem_in hold their last command between accesses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_sel_r    <= REQ_CPU;
      cmd_we_r     <= 1'b0;
      Adr          <= {ADDR_W{1'b0}};
      Mem_in       <= {DATA_W{1'b0}};
      last_grant_r <= REQ_DBG;
    end else if (grant_s) begin
      cmd_sel_r    <= pick_winner_s;
      cmd_we_r     <= sel_we_s;
      Adr          <= sel_adr_s;
      Mem_in       <= sel_wdata_s;
      last_grant_r <= pick_winner_s;
    end else begin
      cmd_sel_r    <= cmd_sel_r;
      cmd_we_r     <= cmd_we_r;
      Adr          <= Adr;
      Mem_in       <= Mem_in;
      last_grant_r <= last_grant_r;
    end
  end

  // Memory strobes are high exactly while the FSM sits in ACC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Mem_read  <= 1'b0;
      Mem_write <= 1'b0;
    end else begin
      Mem_read  <= grant_s & ~sel_we_s;
      Mem_write <= grant_s & sel_we_s;
    end
  end

  // Completion pulse for the served requester, high during DONE only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= (state_r == ACC) && (cmd_sel_r == REQ_CPU);
      ack1 <= (state_r == ACC) && (cmd_sel_r == REQ_DBG);
    end
  end

  // Capture read data for the served requester at the end of a read access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= {DATA_W{1'b0}};
      rdata1 <= {DATA_W{1'b0}};
    end else if ((state_r == ACC) && !cmd_we_r) begin
      if (cmd_sel_r == REQ_DBG) begin
        rdata1 <= Mem_out;
      end else begin
        rdata0 <= Mem_out;
      end
    end else begin
      rdata0 <= rdata0;
      rdata1 <= rdata1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 32x8 memory.
module tb_dmem_arbiter;

  typedef struct {
    logic       we;
    logic [4:0] adr;
    logic [7:0] data;
  } cmd_t;

  typedef struct {
    logic       idx;
    logic       we;
    logic [4:0] adr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic idx;
    int   cyc;
  } log_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [4:0] adr0, adr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       Mem_read, Mem_write;
  logic [4:0] Adr;
  logic [7:0] Mem_in;
  wire  [7:0] Mem_out;

  logic [7:0] mem [0:31];

  cmd_t q0[$];
  cmd_t q1[$];
  exp_t sb[$];
  log_t ack_log[$];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .adr0      (adr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .adr1      (adr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .Mem_read  (Mem_read),
    .Mem_write (Mem_write),
    .Adr       (Adr),
    .Mem_in    (Mem_in),
    .Mem_out   (Mem_out)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at posedge
  assign Mem_out = Mem_read ? mem[Adr] : 8'hzz;
  always @(posedge clk) begin
    if (Mem_write) mem[Adr] <= Mem_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic idx, input logic we, input logic [4:0] adr, input logic [7:0] data);
    cmd_t c;
    exp_t e;
    c.we = we; c.adr = adr; c.data = data;
    e.idx = idx; e.we = we; e.adr = adr; e.data = data;
    if (idx) q1.push_back(c);
    else     q0.push_back(c);
    sb.push_back(e);
  endtask

  // Drive both requesters from their queues until all commands are acked
  task automatic run_queues(input int budget);
    int   cyc;
    cmd_t c;
    cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0 || req1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if ((req0 && ack0) || (!req0 && q0.size() > 0)) begin
        if (q0.size() > 0) begin
          c = q0.pop_front();
          req0 = 1'b1; we0 = c.we; adr0 = c.adr; wdata0 = c.data;
        end else begin
          req0 = 1'b0;
        end
      end
      if ((req1 && ack1) || (!req1 && q1.size() > 0)) begin
        if (q1.size() > 0) begin
          c = q1.pop_front();
          req1 = 1'b1; we1 = c.we; adr1 = c.adr; wdata1 = c.data;
        end else begin
          req1 = 1'b0;
        end
      end
    end
    check("run_within_budget", 32'(cyc < budget), 32'd1);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Check count, requester order and 3-cycle spacing of acks logged since start
  task automatic check_acks(input string name, input int start, input int n, input logic first_idx, input logic alternate);
    logic exp_idx;
    check({name, "_count"}, 32'(ack_log.size() - start), 32'(n));
    exp_idx = first_idx;
    for (int i = start; i < ack_log.size(); i++) begin
      check({name, "_idx"}, 32'(ack_log[i].idx), 32'(exp_idx));
      if (i > start) check({name, "_spacing"}, 32'(ack_log[i].cyc - ack_log[i-1].cyc), 32'd3);
      if (alternate) exp_idx = ~exp_idx;
    end
  endtask

  // Monitor: pops the scoreboard on each ack and checks protocol rules
  initial begin
    int   cyc;
    logic prev_acc;
    logic [7:0] mdl0, mdl1;
    exp_t e;
    log_t l;
    cyc = 0; prev_acc = 1'b0; mdl0 = 8'h00; mdl1 = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        mdl0 = 8'h00; mdl1 = 8'h00; prev_acc = 1'b0;
      end else begin
        if (ack0 && ack1) check("ack_exclusive", 32'd1, 32'd0);
        if (Mem_read && Mem_write) check("strobe_exclusive", 32'd1, 32'd0);
        if (prev_acc) check("acc_one_cycle", 32'(Mem_read | Mem_write), 32'd0);
        prev_acc = Mem_read | Mem_write;
        if (ack0 || ack1) begin
          l.idx = ack1; l.cyc = cyc;
          ack_log.push_back(l);
          if (sb.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("ack_requester", 32'(ack1), 32'(e.idx));
            if (e.we) begin
              check("mem_written", 32'(mem[e.adr]), 32'(e.data));
            end else if (e.idx) begin
              mdl1 = e.data;
            end else begin
              mdl0 = e.data;
            end
            check("rdata0", 32'(rdata0), 32'(mdl0));
            check("rdata1", 32'(rdata1), 32'(mdl1));
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int seen;
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; adr0 = 5'd0; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; adr1 = 5'd0; wdata1 = 8'h00;
    #12;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    check("rst_mem_read", 32'(Mem_read), 32'd0);
    check("rst_mem_write", 32'(Mem_write), 32'd0);
    check("rst_adr", 32'(Adr), 32'd0);
    check("rst_mem_in", 32'(Mem_in), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single write then read on requester 0
    issue(1'b0, 1'b1, 5'd27, 8'h3C);
    issue(1'b0, 1'b0, 5'd27, 8'h3C);
    run_queues(40);

    // Reset in the middle of a write access
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; adr0 = 5'd27; wdata0 = 8'hA5;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (Mem_write) seen = 1;
    end
    check("abort_reached_acc", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_mem_write", 32'(Mem_write), 32'd0);
    check("abort_ack0", 32'(ack0), 32'd0);
    check("abort_rdata0", 32'(rdata0), 32'd0);
    check("abort_adr", 32'(Adr), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem27", 32'(mem[27]), 32'h3C);
    check("abort_no_ack", 32'(ack0 | ack1), 32'd0);
    check("abort_idle", 32'(Mem_read | Mem_write), 32'd0);

    // Conflict right after reset: requester 0 first
    start = ack_log.size();
    issue(1'b0, 1'b0, 5'd27, 8'h3C);
    issue(1'b1, 1'b1, 5'd4, 8'h77);
    run_queues(40);
    check_acks("conflict", start, 2, 1'b0, 1'b1);

    // Sustained contention, 0 read of adr 4 sees requester 1's write
    start = ack_log.size();
    issue(1'b0, 1'b1, 5'd10, 8'h11);
    issue(1'b1, 1'b0, 5'd27, 8'h3C);
    issue(1'b0, 1'b0, 5'd4, 8'h77);
    issue(1'b1, 1'b1, 5'd11, 8'h22);
    run_queues(60);
    check_acks("contention", start, 4, 1'b0, 1'b1);

    // Back-to-back on requester 1: preload, then read back
    issue(1'b1, 1'b1, 5'd0, 8'h01);
    issue(1'b1, 1'b1, 5'd1, 8'h02);
    issue(1'b1, 1'b1, 5'd2, 8'h03);
    run_queues(60);
    start = ack_log.size();
    issue(1'b1, 1'b0, 5'd0, 8'h01);
    issue(1'b1, 1'b0, 5'd1, 8'h02);
    issue(1'b1, 1'b0, 5'd2, 8'h03);
    run_queues(60);
    check_acks("b2b", start, 3, 1'b1, 1'b0);
    check("b2b_rdata1_final", 32'(rdata1), 32'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
